// File: rtl/reg_wb_sched.sv
// Writeback scheduler and hazard scoreboard for a 2R/1W register file.
// Round-robin shares the single write port between the ALU and the load unit.
module reg_wb_sched #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int NREGS    = 32,
  parameter int MAX_PEND = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rs0,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_we,
  output logic             iss_stall,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_addr,
  input  logic [DW-1:0]    alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_data,
  output logic             mem_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [NREGS-1:0] busy,
  output logic [3:0]       pend_cnt,
  output logic             err_spur
);

  logic             ptr_reg;   // 0: ALU has priority, 1: load unit has priority
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [3:0]       pend_reg;
  logic [3:0]       pend_next;
  logic             err_reg;
  logic             wr_en_reg;
  logic [AW-1:0]    wr_addr_reg;
  logic [DW-1:0]    wr_data_reg;

  logic raw_hz, waw_hz, full_hz;
  logic do_set, do_clr;
  logic alu_xfer, mem_xfer, any_xfer;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  assign raw_hz  = (iss_rs0 != '0 && busy_reg[iss_rs0]) ||
                   (iss_rs1 != '0 && busy_reg[iss_rs1]);
  assign waw_hz  = iss_we && iss_rd != '0 && busy_reg[iss_rd];
  assign full_hz = iss_we && iss_rd != '0 && pend_reg == 4'(MAX_PEND);
  assign iss_stall = iss_valid && (raw_hz || waw_hz || full_hz);

  assign do_set = iss_valid && !iss_stall && iss_we && iss_rd != '0;
  assign do_clr = wr_en_reg && busy_reg[wr_addr_reg];

  assign alu_ready = alu_valid && (!mem_valid || !ptr_reg);
  assign mem_ready = mem_valid && (!alu_valid || ptr_reg);
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;
  assign any_xfer  = alu_xfer || mem_xfer;
  assign wb_addr   = alu_xfer ? alu_addr : mem_addr;
  assign wb_data   = alu_xfer ? alu_data : mem_data;

  // Per-register set/clear; set overrides clear so a same-index collision keeps the bit.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
      assign set_vec[gi] = do_set && iss_rd == AW'(gi);
      assign clr_vec[gi] = do_clr && wr_addr_reg == AW'(gi);
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] = set_vec[gi] || (busy_reg[gi] && !clr_vec[gi]);
      end
    end
  endgenerate

  always_comb begin
    pend_next = pend_reg;
    if (do_set && !do_clr && pend_reg != 4'hF)
      pend_next = pend_reg + 4'd1;
    else if (do_clr && !do_set && pend_reg != 4'h0)
      pend_next = pend_reg - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= 1'b0;
      busy_reg    <= '0;
      pend_reg    <= '0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      pend_reg  <= pend_next;
      wr_en_reg <= any_xfer && wb_addr != '0;
      if (any_xfer) begin
        wr_addr_reg <= wb_addr;
        wr_data_reg <= wb_data;
        ptr_reg     <= alu_xfer;
      end
      // A landing write to a non-busy register is flagged but still performed.
      if (wr_en_reg && !busy_reg[wr_addr_reg])
        err_reg <= 1'b1;
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = busy_reg;
  assign pend_cnt = pend_reg;
  assign err_spur = err_reg;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed self-checking bench for reg_wb_sched: reset, RAW, contention, FULL,
// register zero and spurious writebacks.
module tb_reg_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_we, iss_stall;
  logic [4:0]  iss_rs0, iss_rs1, iss_rd;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;
  logic [3:0]  pend_cnt;
  logic        err_spur;

  int n_tests = 0;
  int n_fail  = 0;

  reg_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs0(iss_rs0), .iss_rs1(iss_rs1),
    .iss_rd(iss_rd), .iss_we(iss_we), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .pend_cnt(pend_cnt), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_we = 0; iss_rs0 = 0; iss_rs1 = 0; iss_rd = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic we);
    iss_valid = 1; iss_rs0 = rs0; iss_rs1 = rs1; iss_rd = rd; iss_we = we;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_err", err_spur, 0);

    // Reset mid-operation
    issue(0, 0, 5, 1);
    check("mr_issue_ok", iss_stall, 0);
    tick();
    iss_valid = 0;
    check("mr_busy5", busy, 32'h20);
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    #1;
    rst_n = 0;
    #1;
    check("mr_wr_en", wr_en, 0);
    check("mr_busy", busy, 0);
    check("mr_pend", pend_cnt, 0);
    check("mr_err", err_spur, 0);
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
    check("mr_no_write", wr_en, 0);

    // RAW hazard
    issue(0, 0, 3, 1);
    tick();
    check("raw_pend1", pend_cnt, 1);
    issue(3, 0, 0, 0);
    check("raw_stall", iss_stall, 1);
    alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF;
    #1;
    check("raw_alu_rdy", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    check("raw_wr_en", wr_en, 1);
    check("raw_wr_addr", wr_addr, 3);
    check("raw_wr_data", wr_data, 32'hDEADBEEF);
    check("raw_still_stall", iss_stall, 1);
    tick();
    check("raw_busy_clr", busy, 0);
    check("raw_unstall", iss_stall, 0);
    check("raw_pend0", pend_cnt, 0);
    check("raw_no_spur", err_spur, 0);
    idle_inputs();

    // Contention from reset pointer
    do_reset();
    alu_valid = 1; alu_addr = 10; alu_data = 32'hA1;
    mem_valid = 1; mem_addr = 11; mem_data = 32'hB1;
    #1;
    check("ct0_alu", {alu_ready, mem_ready}, 2'b10);
    tick();
    alu_addr = 12; alu_data = 32'hA2;
    #1;
    check("ct1_mem", {alu_ready, mem_ready}, 2'b01);
    check("ct1_data", wr_data, 32'hA1);
    tick();
    mem_addr = 13; mem_data = 32'hB2;
    #1;
    check("ct2_alu", {alu_ready, mem_ready}, 2'b10);
    check("ct2_data", wr_data, 32'hB1);
    tick();
    check("ct3_mem", {alu_ready, mem_ready}, 2'b01);
    check("ct3_data", wr_data, 32'hA2);
    tick();
    idle_inputs();
    #1;
    check("ct4_data", wr_data, 32'hB2);
    check("ct4_wr_en", wr_en, 1);
    tick();
    check("ct5_idle", wr_en, 0);
    check("ct5_hold", wr_data, 32'hB2);

    // FULL stall
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(0, 0, 5'(i), 1);
      check($sformatf("full_iss%0d", i), iss_stall, 0);
      tick();
    end
    issue(0, 0, 6, 1);
    check("full_stall", iss_stall, 1);
    check("full_pend4", pend_cnt, 4);
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    tick();
    alu_valid = 0;
    #1;
    check("full_wb_wr", wr_en, 1);
    check("full_stall2", iss_stall, 1);
    tick();
    check("full_pend3", pend_cnt, 3);
    check("full_unstall", iss_stall, 0);
    tick();
    iss_valid = 0; iss_rs0 = 6; iss_we = 0;
    #1;
    check("full_busy", busy, 32'h5C);
    check("full_pend_back", pend_cnt, 4);
    check("full_noval_nostall", iss_stall, 0);
    idle_inputs();

    // Register zero and spurious write
    do_reset();
    mem_valid = 1; mem_addr = 0; mem_data = 32'h55;
    #1;
    check("z_mem_rdy", mem_ready, 1);
    tick();
    mem_valid = 0;
    alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    #1;
    check("z_wr_en", wr_en, 0);
    check("sp_alu_rdy", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    check("sp_wr_en", wr_en, 1);
    check("sp_wr_addr", wr_addr, 9);
    check("sp_err_pre", err_spur, 0);
    tick();
    check("sp_err_set", err_spur, 1);
    tick();
    tick();
    check("sp_err_sticky", err_spur, 1);
    check("sp_pend", pend_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Writeback scheduler and hazard scoreboard for the 32-entry register file, which has two read ports and one write port.
- Shares the single write port between the ALU and the load unit using round-robin arbitration.
- Drives a registered wr_en/wr_addr/wr_data into the register file.
- Tracks registers with an outstanding write and stalls issue on RAW/WAW hazards, or when too many writes are outstanding.

Parameters:
AW, 5, register address width
DW, 32, data width
NREGS, 32, register count (2**AW)
MAX_PEND, 4, maximum outstanding writes; valid range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
iss_valid  in  1  decoder presents an instruction
iss_rs0  in  AW  source register 0
iss_rs1  in  AW  source register 1
iss_rd  in  AW  destination register
iss_we  in  1  instruction writes iss_rd
iss_stall  out  1  combinational; issue is blocked this cycle
alu_valid  in  1  ALU writeback request
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
alu_ready  out  1  combinational; ALU granted this cycle
mem_valid  in  1  load-unit writeback request
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
mem_ready  out  1  combinational; load unit granted this cycle
wr_en  out  1  register file write enable (registered)
wr_addr  out  AW  register file write address (registered)
wr_data  out  DW  register file write data (registered)
busy  out  NREGS  scoreboard vector; bit 0 is always 0
pend_cnt  out  4  number of outstanding writes
err_spur  out  1  sticky flag: a writeback targeted a register that was not busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, pend_cnt=0, err_spur=0.
  - Priority pointer set to ALU.
  - Any in-flight transfer is discarded.
- Issue acceptance:
  - An instruction is accepted when iss_valid && !iss_stall.
  - iss_stall = iss_valid && (RAW || WAW || FULL), where:
    - RAW: (rs0!=0 && busy[rs0]) || (rs1!=0 && busy[rs1])
    - WAW: iss_we && rd!=0 && busy[rd]
    - FULL: iss_we && rd!=0 && pend_cnt==MAX_PEND
  - iss_stall is 0 whenever iss_valid is 0.
- Scoreboard:
  - Set: an accepted issue with iss_we && rd!=0 sets busy[rd] at the next edge and increments pend_cnt.
  - Clear: a cycle with wr_en=1 && busy[wr_addr] clears busy[wr_addr] at the next edge and decrements pend_cnt.
  - Because the bit clears only when the write lands, a dependent instruction issues no earlier than the cycle after the register file write.
  - Set and clear in the same cycle on different registers: both apply; pend_cnt is unchanged.
  - Set and clear on the same index cannot occur (blocked by WAW). If it does occur anyway, set wins and pend_cnt is unchanged.
  - pend_cnt never wraps.
- Arbitration:
  - When only one requester is valid, it is granted.
  - When both are valid, the requester indicated by the priority pointer is granted.
  - At most one of alu_ready/mem_ready is 1, and ready is never asserted without the matching valid.
  - Transfer happens when valid && ready are both high.
  - After a transfer, the pointer moves to the other requester.
  - No transfer means the pointer is unchanged.
  - Requesters must hold valid, addr and data stable until the transfer.
- Write port:
  - A transfer in cycle N produces wr_en=1 with the captured addr/data in cycle N+1, which is 1-cycle latency.
  - A transfer with addr==0 is accepted but produces wr_en=0 in N+1; register 0 reads as zero regardless.
  - No transfer means wr_en=0 next cycle; wr_addr and wr_data hold their last values.
  - Throughput: one write per cycle.
- Error:
  - err_spur is set at the edge after a cycle with wr_en=1 && busy[wr_addr]==0.
  - err_spur clears only on reset.
  - A spurious write is still performed.

Test Plan:
- Reset mid-operation: issue rd=5, drive alu_valid to addr 5, then pulse rst_n low before the edge. Expect wr_en, busy, pend_cnt and err_spur all 0 immediately, and no write in the following cycle.
- RAW hazard: issue rd=3. In the next cycle, issue rs0=3: iss_stall=1. ALU writes back addr 3 data 0xDEADBEEF in cycle N: wr_en=1 at N+1, busy[3]=0 at N+2, and iss_stall=0 at N+2.
- Contention: with the pointer at reset value, hold alu_valid and mem_valid high for 4 cycles. Expect grants in the order ALU, MEM, ALU, MEM, with wr_data alternating between the two sources one cycle later.
- FULL stall: with MAX_PEND=4, issue writes to rd=1,2,3,4, then a fifth write to rd=6: iss_stall=1 and pend_cnt=4. After one writeback completes, the fifth write issues.
- Register zero and spurious writes: a mem writeback to addr 0 gives mem_ready=1 and wr_en stays 0. An ALU writeback to addr 9 while busy[9]=0 gives wr_en=1 and err_spur=1 in the following cycle, where it stays set.
